// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions: 640x480@60 defaults, size helpers and
// the coordinate type used by the timing generator and the mapper blocks.
package vga_timing_pkg;

   typedef logic [9:0] coord_t;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;

   localparam int unsigned MAX_TOTAL = 1024;

   function automatic int unsigned raster_total(input int unsigned visible,
                                                input int unsigned front,
                                                input int unsigned sync,
                                                input int unsigned back);
      return visible + front + sync + back;
   endfunction

   // First column/line of the sync pulse.
   function automatic int unsigned sync_start(input int unsigned visible,
                                              input int unsigned front);
      return visible + front;
   endfunction

   // One past the last column/line of the sync pulse.
   function automatic int unsigned sync_end(input int unsigned visible,
                                            input int unsigned front,
                                            input int unsigned sync);
      return visible + front + sync;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage, W-bit shift register with asynchronous active-low reset to RST_VAL.
// N = 0 is a plain combinational pass-through.
module vga_sync_delay #(
   parameter int unsigned N       = 2,
   parameter int unsigned W       = 3,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o
);

   if (N == 0) begin : g_pass
      logic unused_s;
      assign unused_s = clk_i ^ rst_ni;
      assign data_o   = data_i;
   end else begin : g_pipe
      logic [W-1:0] stage_q [N];

      // Shift chain; every stage resets to the idle sync levels.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int unsigned i = 0; i < N; i++) begin
               stage_q[i] <= RST_VAL;
            end
         end else begin
            stage_q[0] <= data_i;
            for (int unsigned i = 1; i < N; i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign data_o = stage_q[N-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, visible-area and sync decode,
// start-of-frame pulse, frame counter and pipeline-aligned sync copies.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT    = DEF_H_FRONT,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BACK     = DEF_H_BACK,
   parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT    = DEF_V_FRONT,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BACK     = DEF_V_BACK,
   parameter int unsigned PIPE_DELAY = 2,
   parameter int unsigned FRAME_W    = 8
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   output coord_t             DrawX,
   output coord_t             DrawY,
   output logic               blank,
   output logic               hs,
   output logic               vs,
   output logic               hs_d,
   output logic               vs_d,
   output logic               blank_d,
   output logic               sof,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int unsigned H_TOTAL  = raster_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL  = raster_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam int unsigned HS_START = sync_start(H_VISIBLE, H_FRONT);
   localparam int unsigned HS_END   = sync_end(H_VISIBLE, H_FRONT, H_SYNC);
   localparam int unsigned VS_START = sync_start(V_VISIBLE, V_FRONT);
   localparam int unsigned VS_END   = sync_end(V_VISIBLE, V_FRONT, V_SYNC);
   localparam coord_t      H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t      V_LAST   = coord_t'(V_TOTAL - 1);

   if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL) || (PIPE_DELAY > 7)) begin : g_bad_params
      $error("vga_timing_gen: raster totals must be <= 1024 and PIPE_DELAY <= 7");
   end

   coord_t             x_q, x_d;
   coord_t             y_q, y_d;
   logic               vis_q, vis_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               sof_q, sof_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [2:0]         sync_dly_s;

   // Next raster position: column wraps at the line end and carries into the line.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (x_q == H_LAST) begin
         x_d = 10'd0;
         if (y_q == V_LAST) begin
            y_d = 10'd0;
         end else begin
            y_d = y_q + 10'd1;
         end
      end else begin
         x_d = x_q + 10'd1;
      end
   end

   // Decode from the next position so the registered flags line up with the counters.
   always_comb begin
      vis_d   = (32'(x_d) < H_VISIBLE) && (32'(y_d) < V_VISIBLE);
      hsync_d = !((32'(x_d) >= HS_START) && (32'(x_d) < HS_END));
      vsync_d = !((32'(y_d) >= VS_START) && (32'(y_d) < VS_END));
      sof_d   = (x_d == 10'd0) && (y_d == 10'd0);
      if (sof_d) begin
         frame_d = frame_q + FRAME_W'(1'b1);
      end else begin
         frame_d = frame_q;
      end
   end

   // Timing state; reset parks the raster on its last position so release starts a frame.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q     <= H_LAST;
         y_q     <= V_LAST;
         vis_q   <= 1'b0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         sof_q   <= 1'b0;
         frame_q <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         vis_q   <= vis_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         sof_q   <= sof_d;
         frame_q <= frame_d;
      end
   end

   vga_sync_delay #(
      .N       (PIPE_DELAY),
      .W       (3),
      .RST_VAL (3'b110)
   ) u_sync_delay (
      .clk_i  (vga_clk),
      .rst_ni (reset_n),
      .data_i ({hsync_q, vsync_q, vis_q}),
      .data_o (sync_dly_s)
   );

   assign DrawX       = x_q;
   assign DrawY       = y_q;
   assign blank       = vis_q;
   assign hs          = hsync_q;
   assign vs          = vsync_q;
   assign sof         = sof_q;
   assign frame_count = frame_q;
   assign hs_d        = sync_dly_s[2];
   assign vs_d        = sync_dly_s[1];
   assign blank_d     = sync_dly_s[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance (PIPE_DELAY=2) and a tiny raster
// instance (16x9, PIPE_DELAY=0, FRAME_W=2) checked every clock against a model.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank;
      logic       hs;
      logic       vs;
      logic       sof;
      logic [7:0] frame;
      logic       hs_d;
      logic       vs_d;
      logic       blank_d;
   } obs_t;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 vga_clk = ~vga_clk;

   coord_t     x0, y0, x1, y1;
   logic       bl0, hs0, vs0, hsd0, vsd0, bld0, sof0;
   logic       bl1, hs1, vs1, hsd1, vsd1, bld1, sof1;
   logic [7:0] fc0;
   logic [1:0] fc1;

   vga_timing_gen dut0 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x0), .DrawY(y0),
      .blank(bl0), .hs(hs0), .vs(vs0), .hs_d(hsd0), .vs_d(vsd0),
      .blank_d(bld0), .sof(sof0), .frame_count(fc0)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .PIPE_DELAY(0), .FRAME_W(2)
   ) dut1 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x1), .DrawY(y1),
      .blank(bl1), .hs(hs1), .vs(vs1), .hs_d(hsd1), .vs_d(vsd1),
      .blank_d(bld1), .sof(sof1), .frame_count(fc1)
   );

   // Independent timing tables for the two instances.
   int p_ht[2]  = '{800, 16};
   int p_vt[2]  = '{525, 9};
   int p_hv[2]  = '{640, 8};
   int p_vv[2]  = '{480, 4};
   int p_hss[2] = '{656, 10};
   int p_hse[2] = '{752, 13};
   int p_vss[2] = '{490, 5};
   int p_vse[2] = '{492, 7};
   int p_pd[2]  = '{2, 0};
   int p_fm[2]  = '{256, 4};

   int         m_x[2], m_y[2], m_f[2];
   logic       m_sof[2];
   logic [2:0] m_u[2];
   logic [2:0] m_hist[2][8];
   obs_t       sb0[$], sb1[$];

   int n_checks = 0;
   int n_pass   = 0;
   int hs_run0, vs_run1, sof_gap1, sof_cnt1;
   bit sof_seen1;
   logic [1:0] fc_seq[4] = '{2'd1, 2'd2, 2'd3, 2'd0};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic obs_t expect_of(input int i);
      obs_t       e;
      logic [2:0] d;
      d = (p_pd[i] == 0) ? m_u[i] : m_hist[i][p_pd[i]-1];
      e.x       = 10'(m_x[i]);
      e.y       = 10'(m_y[i]);
      e.hs      = m_u[i][2];
      e.vs      = m_u[i][1];
      e.blank   = m_u[i][0];
      e.sof     = m_sof[i];
      e.frame   = 8'(m_f[i]);
      e.hs_d    = d[2];
      e.vs_d    = d[1];
      e.blank_d = d[0];
      return e;
   endfunction

   task automatic push_exp(input int i);
      if (i == 0) sb0.push_back(expect_of(0));
      else        sb1.push_back(expect_of(1));
   endtask

   task automatic model_reset(input int i);
      m_x[i]   = p_ht[i] - 1;
      m_y[i]   = p_vt[i] - 1;
      m_f[i]   = 0;
      m_sof[i] = 1'b0;
      m_u[i]   = 3'b110;
      for (int k = 0; k < 8; k++) m_hist[i][k] = 3'b110;
      push_exp(i);
   endtask

   task automatic model_edge(input int i);
      for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = m_u[i];
      if (m_x[i] == p_ht[i] - 1) begin
         m_x[i] = 0;
         m_y[i] = (m_y[i] == p_vt[i] - 1) ? 0 : m_y[i] + 1;
      end else begin
         m_x[i] = m_x[i] + 1;
      end
      m_sof[i] = (m_x[i] == 0) && (m_y[i] == 0);
      if (m_sof[i]) m_f[i] = (m_f[i] + 1) % p_fm[i];
      m_u[i][2] = !((m_x[i] >= p_hss[i]) && (m_x[i] < p_hse[i]));
      m_u[i][1] = !((m_y[i] >= p_vss[i]) && (m_y[i] < p_vse[i]));
      m_u[i][0] = (m_x[i] < p_hv[i]) && (m_y[i] < p_vv[i]);
      push_exp(i);
   endtask

   function automatic obs_t obs_of(input int i);
      obs_t o;
      if (i == 0) begin
         o = '{x: x0, y: y0, blank: bl0, hs: hs0, vs: vs0, sof: sof0, frame: fc0,
               hs_d: hsd0, vs_d: vsd0, blank_d: bld0};
      end else begin
         o = '{x: x1, y: y1, blank: bl1, hs: hs1, vs: vs1, sof: sof1, frame: {6'd0, fc1},
               hs_d: hsd1, vs_d: vsd1, blank_d: bld1};
      end
      return o;
   endfunction

   task automatic compare_all();
      obs_t e;
      if (sb0.size() > 0) begin
         e = sb0.pop_front();
         check_eq("dut0_state", obs_of(0), e);
      end
      if (sb1.size() > 0) begin
         e = sb1.pop_front();
         check_eq("dut1_state", obs_of(1), e);
      end
   endtask

   task automatic clear_stats();
      hs_run0   = 0;
      vs_run1   = 0;
      sof_gap1  = 0;
      sof_cnt1  = 0;
      sof_seen1 = 1'b0;
   endtask

   // Pulse widths, sof spacing and the 2-bit frame sequence, measured on the DUT outputs.
   task automatic run_stats();
      if (!hs0) hs_run0++;
      else if (hs_run0 != 0) begin
         check_eq("hs_width", hs_run0, 96);
         hs_run0 = 0;
      end
      if (!vs1) vs_run1++;
      else if (vs_run1 != 0) begin
         check_eq("vs_width_small", vs_run1, 32);
         vs_run1 = 0;
      end
      sof_gap1++;
      if (sof1) begin
         if (sof_seen1) check_eq("sof_period_small", sof_gap1, 144);
         check_eq("frame_seq_small", fc1, fc_seq[sof_cnt1 % 4]);
         sof_cnt1++;
         sof_gap1  = 0;
         sof_seen1 = 1'b1;
      end
   endtask

   task automatic reset_now();
      for (int i = 0; i < 2; i++) model_reset(i);
      clear_stats();
      compare_all();
   endtask

   task automatic tick();
      @(posedge vga_clk);
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) model_reset(i);
         else          model_edge(i);
      end
      #1;
      compare_all();
      if (reset_n) run_stats();
      else         clear_stats();
   endtask

   task automatic first_edge_checks();
      check_eq("first_x", x0, 0);
      check_eq("first_y", y0, 0);
      check_eq("first_blank", bl0, 1);
      check_eq("first_sof", sof0, 1);
      check_eq("first_frame", fc0, 1);
   endtask

   initial begin
      int guard;
      clear_stats();
      #1 reset_n = 1'b0;
      #1 reset_now();
      check_eq("rst_x", x0, 799);
      check_eq("rst_y", y0, 524);
      check_eq("rst_blank", bl0, 0);
      check_eq("rst_hs_vs", {hs0, vs0}, 2'b11);
      repeat (2) tick();
      #6 reset_n = 1'b1;
      tick();
      first_edge_checks();
      repeat (1000) tick();
      guard = 0;
      while (!((x0 == 10'd300) && (y0 == 10'd1)) && (guard < 2000)) begin
         tick();
         guard++;
      end
      check_eq("mid_reset_pos", {x0, y0}, {10'd300, 10'd1});
      #3 reset_n = 1'b0;
      #1 reset_now();
      check_eq("mid_rst_x", x0, 799);
      check_eq("mid_rst_frame", fc0, 0);
      repeat (2) tick();
      #3 reset_n = 1'b1;
      tick();
      first_edge_checks();
      repeat (1700) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that drives the pixel-coordinate side of every picture/tile mapper in the display path. It produces `DrawX`/`DrawY`, the visible-area `blank` flag, active-low `hs`/`vs`, a start-of-frame pulse and a frame counter. It also outputs copies of `hs`/`vs`/`blank` delayed by the mapper pipeline depth, so sync stays aligned with the mapper's registered RGB.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in clocks
- `H_SYNC`, 96: hsync pulse width, in clocks
- `H_BACK`, 48: horizontal back porch, in clocks
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `PIPE_DELAY`, 2: mapper latency in clocks; range 0..7
- `FRAME_W`, 8: frame counter width

Ports:
- `vga_clk` input 1: pixel clock; all state is in this domain
- `reset_n` input 1: asynchronous, active-low reset
- `DrawX` output 10: current column, 0..H_TOTAL-1
- `DrawY` output 10: current line, 0..V_TOTAL-1
- `blank` output 1: 1 = visible pixel, aligned with `DrawX`/`DrawY`
- `hs` output 1: hsync, active low, aligned with `DrawX`
- `vs` output 1: vsync, active low, aligned with `DrawY`
- `hs_d` output 1: `hs` delayed `PIPE_DELAY` clocks
- `vs_d` output 1: `vs` delayed `PIPE_DELAY` clocks
- `blank_d` output 1: `blank` delayed `PIPE_DELAY` clocks
- `sof` output 1: one-clock pulse while (`DrawX`,`DrawY`) = (0,0)
- `frame_count` output FRAME_W: completed-frame counter

## Operation
- Derived sizes: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK, which is 800 at defaults. V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK, which is 525 at defaults.
- Both totals must be ≤ 1024. An elaboration-time assertion enforces this.
- `DrawX` and `DrawY` are the counter registers themselves.
- Horizontal counting: `DrawX` increments every clock. When it is H_TOTAL-1 it wraps to 0 and `DrawY` advances.
- Vertical counting: `DrawY` wraps from V_TOTAL-1 to 0.
- `blank`, `hs`, `vs` and `sof` are registered and decoded from next-state counters, so they are coincident with the counters and never lag them.
  - `blank` = (`DrawX` < H_VISIBLE) && (`DrawY` < V_VISIBLE).
  - `hs` = 0 iff H_VISIBLE+H_FRONT ≤ `DrawX` < H_VISIBLE+H_FRONT+H_SYNC. At defaults this is 656..751.
  - `vs` = 0 iff V_VISIBLE+V_FRONT ≤ `DrawY` < V_VISIBLE+V_FRONT+V_SYNC. At defaults this is 490..491, for the whole line.
  - `sof` = 1 only at (0,0).
- `frame_count` increments, modulo 2^FRAME_W, on each transition into (0,0).
- Delay line: `hs_d`/`vs_d`/`blank_d` come from a `PIPE_DELAY`-stage shift register. With `PIPE_DELAY`=0 they equal `hs`/`vs`/`blank` combinationally.
- Reset (asserts asynchronously, releases synchronously to the next `vga_clk` edge):
  - `DrawX`=H_TOTAL-1 and `DrawY`=V_TOTAL-1, i.e. the last position.
  - `blank`=0, `hs`=1, `vs`=1, `sof`=0, `frame_count`=0.
  - Every delay stage resets to `hs_d`=1, `vs_d`=1, `blank_d`=0.
- Reset asserted mid-frame forces these values immediately. No partial line is completed.

## Timing
- First `vga_clk` edge after `reset_n` rises: `DrawX`=0, `DrawY`=0, `blank`=1, `sof`=1, `frame_count`=1.
- Line period is H_TOTAL clocks and frame period is H_TOTAL·V_TOTAL clocks. At defaults these are 800 and 420000.
- `sof` pulses are exactly one frame period apart. `frame_count` changes on the same edge `sof` rises.
- `blank_d`, `hs_d` and `vs_d` lag `blank`, `hs` and `vs` by exactly `PIPE_DELAY` edges. The delayed outputs show reset values during the first `PIPE_DELAY` clocks after reset release.
- The outputs are glitch-free: all are register outputs, except the `PIPE_DELAY`=0 pass-through.

## Structure
- `vga_timing_pkg` holds:
  - default timing localparams (640x480@60 set);
  - `function` helpers computing H_TOTAL, V_TOTAL and the sync start/end columns and lines;
  - a `coord_t` typedef (logic [9:0]) shared with the mapper blocks.
- One sub-module, `vga_sync_delay`: a parameterised N-stage, W-bit shift register with async active-low reset to a parameterised reset value. It carries {`hs`,`vs`,`blank`} and its reset value is {1,1,0}.
- The horizontal and vertical counters and the decode logic live in the top module.

## Test plan
- Reset/release, defaults:
  - Hold `reset_n`=0 and check `DrawX`=799, `DrawY`=524, `blank`=0, `hs`=`vs`=1.
  - Release, then check that the first edge gives (0,0), `blank`=1, `sof`=1, `frame_count`=1.
- One line:
  - `blank` falls when `DrawX` goes 639→640.
  - `hs` is low for `DrawX` 656..751 (96 clocks).
  - `DrawY` increments when `DrawX` wraps 799→0.
- Full frame:
  - `vs` is low for `DrawY` 490..491, 1600 clocks total.
  - `sof` intervals are exactly 420000 clocks.
  - `frame_count` goes 1→2→3.
- `PIPE_DELAY`=2:
  - Every `hs_d`/`vs_d`/`blank_d` edge occurs exactly 2 clocks after the matching undelayed edge.
  - Rerun with `PIPE_DELAY`=0 and check the delayed outputs equal the undelayed ones.
- Mid-frame reset:
  - Assert `reset_n`=0 at (300,100) between clock edges and check the outputs take reset values before the next edge.
  - Release and check the frame restarts at (0,0) with `frame_count`=1.
- `FRAME_W`=2 wrap: run 4 frames and check `frame_count` goes 1,2,3,0.
